queen_solver_arbiter: RTL and testbench

Shares one eight_queen solver instance between NUM_REQ requesters.
- Round-robin arbitration between requesters.
- Launches the solver for the granted requester and tags its 8-row solution stream with the requester id.
- Recovers the solver by resetting it if a job hangs or its output stream breaks.
- Sits between the requester blocks and the eight_queen top; drives that top's start/user_reset and consumes its ready/done/out_bus.

---
 rtl/queen_solver_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_queen_solver_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queen_solver_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : queen_solver_arbiter
// Purpose  : Shares one eight_queen solver between NUM_REQ requesters.
//            Round-robin arbitration picks a requester, the solver is
//            launched, and its 8-row solution stream is re-issued tagged with
//            the owner id. A hung job (no output within TIMEOUT busy cycles)
//            or a broken stream (solver_done drops before row 7) resets the
//            solver for two cycles and reports res_error to the owner.
// Ports    : clk           rising-edge clock
//            user_reset    asynchronous active-low reset
//            req/gnt       level requests / one-cycle one-hot acknowledge
//            busy          high whenever the arbiter is not idle
//            solver_start  one-cycle start pulse to the solver
//            solver_reset  active-high recovery reset to the solver
//            solver_ready  solver can accept a start
//            solver_done   high for 8 cycles, one row per cycle
//            solver_bus    one-hot queen column of the current row
//            res_valid/res_id/res_idx/res_row/res_last  registered row stream
//            res_error     one-cycle abort pulse, res_id names the owner
//            stat_jobs     (QUEEN_ARB_STATS_EN only) 16-bit saturating count
//                          of completed jobs per requester, requester 0 in LSBs
// Options  : define QUEEN_ARB_STATS_EN to add the stat_jobs counters.
// Revision : 1.0  initial release
// ============================================================================
module queen_solver_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 4096,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               user_reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               solver_start,
  output logic               solver_reset,
  input  logic               solver_ready,
  input  logic               solver_done,
  input  logic [7:0]         solver_bus,
  output logic               res_valid,
  output logic [ID_W-1:0]    res_id,
  output logic [2:0]         res_idx,
  output logic [7:0]         res_row,
  output logic               res_last,
  output logic               res_error
`ifdef QUEEN_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_jobs
`endif
);

  localparam int c_tmr_w = $clog2(TIMEOUT) + 1;
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_launch  = 3'd1;
  localparam logic [2:0] c_st_busy    = 3'd2;
  localparam logic [2:0] c_st_stream  = 3'd3;
  localparam logic [2:0] c_st_recover = 3'd4;

  logic [2:0]         r_state;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_last_grant;
  logic [c_tmr_w-1:0] r_timer;
  logic [2:0]         r_idx;
  logic               r_rec_cnt;

  logic               r_res_valid;
  logic [ID_W-1:0]    r_res_id;
  logic [2:0]         r_res_idx;
  logic [7:0]         r_res_row;
  logic               r_res_last;
  logic               r_res_error;

  logic [ID_W-1:0]    w_pick;
  logic [ID_W-1:0]    w_pick_hi;
  logic [ID_W-1:0]    w_pick_lo;
  logic               w_any_hi;

  // Round-robin: the lowest requesting index above the last grant wins;
  // if none exists, wrap around to the lowest requesting index overall.
  always_comb begin
    w_pick_hi = '0;
    w_pick_lo = '0;
    w_any_hi  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_pick_lo = ID_W'(i);
        if (ID_W'(i) > r_last_grant) begin
          w_pick_hi = ID_W'(i);
          w_any_hi  = 1'b1;
        end
      end
    end
    w_pick = w_any_hi ? w_pick_hi : w_pick_lo;
  end

  always_comb begin
    gnt = '0;
    if (r_state == c_st_launch) begin
      gnt = NUM_REQ'(1) << r_id;
    end
  end

  assign busy         = (r_state != c_st_idle);
  assign solver_start = (r_state == c_st_launch);
  assign solver_reset = (r_state == c_st_recover);

  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_idx   = r_res_idx;
  assign res_row   = r_res_row;
  assign res_last  = r_res_last;
  assign res_error = r_res_error;

  always_ff @(posedge clk or negedge user_reset) begin
    if (!user_reset) begin
      r_state      <= c_st_idle;
      r_id         <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_timer      <= '0;
      r_idx        <= '0;
      r_rec_cnt    <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_id     <= '0;
      r_res_idx    <= '0;
      r_res_row    <= '0;
      r_res_last   <= 1'b0;
      r_res_error  <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      r_res_error <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if ((|req) && solver_ready) begin
            r_id    <= w_pick;
            r_state <= c_st_launch;
          end
        end
        c_st_launch: begin
          r_timer <= '0;
          r_state <= c_st_busy;
        end
        c_st_busy: begin
          r_timer <= r_timer + c_tmr_w'(1);
          // A first row arriving on the final allowed cycle still wins.
          if (solver_done) begin
            r_res_valid <= 1'b1;
            r_res_id    <= r_id;
            r_res_idx   <= 3'd0;
            r_res_row   <= solver_bus;
            r_idx       <= 3'd1;
            r_state     <= c_st_stream;
          end else if (r_timer == c_tmr_last) begin
            r_rec_cnt <= 1'b0;
            r_state   <= c_st_recover;
          end
        end
        c_st_stream: begin
          if (solver_done) begin
            r_res_valid <= 1'b1;
            r_res_id    <= r_id;
            r_res_idx   <= r_idx;
            r_res_row   <= solver_bus;
            r_res_last  <= (r_idx == 3'd7);
            r_idx       <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_last_grant <= r_id;
              r_state      <= c_st_idle;
            end
          end else begin
            // Stream broke before the last row: rows already sent stand.
            r_rec_cnt <= 1'b0;
            r_state   <= c_st_recover;
          end
        end
        c_st_recover: begin
          r_rec_cnt <= 1'b1;
          if (r_rec_cnt) begin
            r_res_error  <= 1'b1;
            r_res_id     <= r_id;
            r_last_grant <= r_id;
            r_state      <= c_st_idle;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

`ifdef QUEEN_ARB_STATS_EN
  // A job completes on the edge that captures row 7, so the count moves in
  // step with res_last becoming visible.
  logic w_job_done;
  assign w_job_done = (r_state == c_st_stream) && solver_done && (r_idx == 3'd7);

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      logic [15:0] r_stat;
      always_ff @(posedge clk or negedge user_reset) begin
        if (!user_reset) begin
          r_stat <= '0;
        end else if (w_job_done && (r_id == ID_W'(g)) && (r_stat != 16'hFFFF)) begin
          r_stat <= r_stat + 16'd1;
        end
      end
      assign stat_jobs[g*16 +: 16] = r_stat;
    end
  endgenerate
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_queen_solver_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_queen_solver_arbiter
// Purpose  : Self-checking bench for queen_solver_arbiter. A job-level model
//            lays out, at grant time, the whole expected timeline of a job
//            (grant, busy span, rows, recovery, error) from the timing rules;
//            one compare step checks every DUT output each cycle against it.
// Revision : 1.0  initial release
// ============================================================================
module tb_queen_solver_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 16;
  localparam int ID_W    = 3;
  localparam int MAXC    = 6000;

  logic               clk = 1'b0;
  logic               user_reset;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               busy, solver_start, solver_reset;
  logic               solver_ready, solver_done;
  logic [7:0]         solver_bus;
  logic               res_valid, res_last, res_error;
  logic [ID_W-1:0]    res_id;
  logic [2:0]         res_idx;
  logic [7:0]         res_row;
`ifdef QUEEN_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] stat_jobs;
  int                    model_jobs [NUM_REQ];
`endif

  always #5 clk = ~clk;

  queen_solver_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
    .clk(clk), .user_reset(user_reset), .req(req), .gnt(gnt), .busy(busy),
    .solver_start(solver_start), .solver_reset(solver_reset),
    .solver_ready(solver_ready), .solver_done(solver_done), .solver_bus(solver_bus),
    .res_valid(res_valid), .res_id(res_id), .res_idx(res_idx), .res_row(res_row),
    .res_last(res_last), .res_error(res_error)
`ifdef QUEEN_ARB_STATS_EN
    , .stat_jobs(stat_jobs)
`endif
  );

  // Expected timeline, indexed by cycle number.
  bit [NUM_REQ-1:0] e_gnt [MAXC];
  bit               e_start [MAXC], e_busy [MAXC], e_sreset [MAXC];
  bit               e_valid [MAXC], e_last [MAXC], e_error [MAXC];
  bit [7:0]         e_row [MAXC];
  bit [2:0]         e_idx [MAXC];
  int               e_id [MAXC];
  bit               d_done [MAXC];
  bit [7:0]         d_bus [MAXC];

  bit [7:0] fixed_rows [8] = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};

  int n_checks = 0, n_fail = 0;
  int cyc = 0, next_free = 0, lg = NUM_REQ - 1, lg_next = 0, lg_upd = 0;
  bit lg_pend = 1'b0;
  // Stimulus controls.
  bit oneshot = 1'b1, rand_req = 1'b0, rand_ready = 1'b0, plan_rand = 1'b0;
  int plan_kind = 0, plan_k = 8, plan_lat = 5, stop_after = 0;
  // Observation log for the literal checks.
  int glog[$], gcyc[$];
  bit [7:0] vrow[$];
  int nval = 0, nlast = 0, nsr = 0, nerr = 0, errc = 0, lastc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return 0;
  endfunction

  // kind 0: full 8-row job, 1: stream stops after k rows, 2: solver stays silent.
  task automatic plan_job(input int id, input int g);
    int kind, k, lat, s, end_busy, r;
    bit [7:0] row;
    if (plan_rand) begin
      r    = $urandom_range(0, 9);
      kind = (r < 6) ? 0 : (r < 8) ? 1 : 2;
      k    = $urandom_range(1, 7);
      lat  = $urandom_range(1, TIMEOUT);
    end else begin
      kind = plan_kind; k = plan_k; lat = plan_lat;
    end
    e_gnt[g]   = NUM_REQ'(1) << id;
    e_start[g] = 1'b1;
    if (kind == 2) begin
      end_busy = g + TIMEOUT + 2;
      e_sreset[g+TIMEOUT+1] = 1'b1;
      e_sreset[g+TIMEOUT+2] = 1'b1;
      e_error[g+TIMEOUT+3]  = 1'b1;
      e_id[g+TIMEOUT+3]     = id;
    end else begin
      s = g + lat;
      if (kind == 0) k = 8;
      for (int i = 0; i < k; i++) begin
        row = plan_rand ? (8'd1 << $urandom_range(0, 7)) : fixed_rows[i];
        d_done[s+i]  = 1'b1;
        d_bus[s+i]   = row;
        e_valid[s+i+1] = 1'b1;
        e_row[s+i+1]   = row;
        e_idx[s+i+1]   = 3'(i);
        e_id[s+i+1]    = id;
      end
      if (kind == 0) begin
        e_last[s+8] = 1'b1;
        end_busy    = s + 7;
      end else begin
        end_busy = s + k + 2;
        e_sreset[s+k+1] = 1'b1;
        e_sreset[s+k+2] = 1'b1;
        e_error[s+k+3]  = 1'b1;
        e_id[s+k+3]     = id;
      end
    end
    for (int c = g; c <= end_busy; c++) e_busy[c] = 1'b1;
    next_free = end_busy + 1;
    lg_pend = 1'b1; lg_next = id; lg_upd = end_busy + 1;
  endtask

  task automatic compare();
    chk("gnt", 32'(gnt), 32'(e_gnt[cyc]));
    chk("solver_start", 32'(solver_start), 32'(e_start[cyc]));
    chk("busy", 32'(busy), 32'(e_busy[cyc]));
    chk("solver_reset", 32'(solver_reset), 32'(e_sreset[cyc]));
    chk("res_valid", 32'(res_valid), 32'(e_valid[cyc]));
    chk("res_last", 32'(res_last), 32'(e_last[cyc]));
    chk("res_error", 32'(res_error), 32'(e_error[cyc]));
    if (e_valid[cyc]) begin
      chk("res_row", 32'(res_row), 32'(e_row[cyc]));
      chk("res_idx", 32'(res_idx), 32'(e_idx[cyc]));
    end
    if (e_valid[cyc] || e_error[cyc]) chk("res_id", 32'(res_id), 32'(e_id[cyc]));
`ifdef QUEEN_ARB_STATS_EN
    if (e_last[cyc]) model_jobs[e_id[cyc]]++;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i] === 1'b1) begin glog.push_back(i); gcyc.push_back(cyc); end
    end
    if (res_valid === 1'b1) begin nval++; vrow.push_back(res_row); end
    if (res_last === 1'b1) begin nlast++; lastc = cyc; end
    if (solver_reset === 1'b1) nsr++;
    if (res_error === 1'b1) begin nerr++; errc = cyc; end
  endtask

  task automatic clr_log();
    glog.delete(); gcyc.delete(); vrow.delete();
    nval = 0; nlast = 0; nsr = 0; nerr = 0; errc = 0; lastc = 0;
  endtask

  task automatic step();
    compare();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i] === 1'b1) begin
        if (oneshot) req[i] = 1'b0;
        if (rand_req) req[i] = ($urandom_range(0, 3) == 0);
      end else if (rand_req && !req[i]) begin
        req[i] = ($urandom_range(0, 5) == 0);
      end
    end
    if (stop_after > 0 && glog.size() >= stop_after) req = '0;
    if (rand_ready) solver_ready = ($urandom_range(0, 4) != 0);
    solver_done = d_done[cyc];
    solver_bus  = d_bus[cyc];
    if (lg_pend && cyc >= lg_upd) begin lg = lg_next; lg_pend = 1'b0; end
    if (cyc >= next_free && solver_ready && (|req)) plan_job(pick(req, lg), cyc + 1);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Asserted away from the clock edge; outputs must clear without a clock.
  task automatic do_reset();
    user_reset = 1'b0; req = '0; solver_done = 1'b0; solver_bus = '0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_valid", 32'(res_valid), 32'd0);
    chk("async_rst_row", 32'(res_row), 32'd0);
    chk("async_rst_err", 32'(res_error), 32'd0);
    chk("async_rst_sreset", 32'(solver_reset), 32'd0);
    for (int c = cyc; c < MAXC; c++) begin
      e_gnt[c] = '0; e_start[c] = 0; e_busy[c] = 0; e_sreset[c] = 0;
      e_valid[c] = 0; e_last[c] = 0; e_error[c] = 0; d_done[c] = 0; d_bus[c] = '0;
    end
    lg = NUM_REQ - 1; lg_pend = 1'b0; next_free = cyc;
`ifdef QUEEN_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) model_jobs[i] = 0;
`endif
    run(2);
    user_reset = 1'b1;
    next_free = cyc;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    user_reset = 1'b1; req = '0; solver_ready = 1'b0; solver_done = 1'b0; solver_bus = '0;
    #2 user_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_valid", 32'(res_valid), 32'd0);
    user_reset = 1'b1;
    cyc = 0; next_free = 0;
`ifdef QUEEN_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) model_jobs[i] = 0;
`endif

    // Single full job for requester 0, rows start 5 cycles after start.
    solver_ready = 1'b1; req = 2'b01; plan_kind = 0; plan_lat = 5;
    run(20);
    chk("t1_grants", glog.size(), 1);
    if (glog.size() > 0) begin
      chk("t1_gnt_id", glog[0], 0);
      chk("t1_gnt_cycle", gcyc[0], 1);
    end
    chk("t1_rows", nval, 8);
    chk("t1_last_cycle", lastc, 14);
    if (vrow.size() == 8) begin
      chk("t1_row2", 32'(vrow[2]), 32'h80);
      chk("t1_row7", 32'(vrow[7]), 32'h08);
    end

    // Both requesting continuously: fair alternation from a fresh pointer.
    do_reset(); clr_log();
    oneshot = 1'b0; stop_after = 3; plan_lat = 3; req = 2'b11;
    for (int i = 0; i < 150 && glog.size() < 3; i++) step();
    run(30);
    stop_after = 0; oneshot = 1'b1;
    chk("t2_grants", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("t2_order0", glog[0], 0);
      chk("t2_order1", glog[1], 1);
      chk("t2_order2", glog[2], 0);
    end

    // Silent solver: timeout, recovery, then a normal job.
    clr_log();
    plan_kind = 2; req = 2'b01;
    run(30);
    chk("t3_errors", nerr, 1);
    chk("t3_sreset_cycles", nsr, 2);
    if (gcyc.size() > 0) chk("t3_err_delay", errc - gcyc[0], TIMEOUT + 3);
    plan_kind = 0; req = 2'b10;
    run(25);
    chk("t3_next_grant", glog.size(), 2);

    // Stream breaks after 3 rows.
    clr_log();
    plan_kind = 1; plan_k = 3; plan_lat = 2; req = 2'b01;
    run(30);
    chk("t4_rows", nval, 3);
    chk("t4_last", nlast, 0);
    chk("t4_sreset_cycles", nsr, 2);
    chk("t4_errors", nerr, 1);

    // Reset in the middle of a stream.
    clr_log();
    plan_kind = 0; plan_lat = 2; req = 2'b01;
    for (int i = 0; i < 40 && nval < 3; i++) step();
    chk("t5_in_stream", 32'(nval >= 3), 32'd1);
    do_reset();
    req = 2'b10;
    run(20);
    req = 2'b11;
    run(40);
    chk("t5_errors", nerr, 0);
    chk("t5_grants", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("t5_after_rst", glog[1], 1);
      chk("t5_both_first", glog[2], 0);
    end

    // Three completed jobs and one aborted job for requester 1.
    do_reset(); clr_log();
    plan_kind = 0; plan_lat = 3;
    repeat (3) begin req = 2'b10; run(20); end
    plan_kind = 2; req = 2'b10; run(25);
    chk("t6_completed", nlast, 3);
`ifdef QUEEN_ARB_STATS_EN
    chk("t6_stat1", 32'(stat_jobs[31:16]), 32'd3);
    chk("t6_stat0", 32'(stat_jobs[15:0]), 32'd0);
`endif

    // Randomized traffic.
    rand_req = 1'b1; rand_ready = 1'b1; plan_rand = 1'b1;
    run(2500);
    rand_req = 1'b0; rand_ready = 1'b0; solver_ready = 1'b1; req = '0;
    run(60);
`ifdef QUEEN_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) chk("stat_jobs", 32'(stat_jobs[i*16 +: 16]), model_jobs[i]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
